// File: rtl/aud_i2s_player_if.sv
// Player-side signal bundle for the I2S DAC serialiser.
// The master side supplies enable, mute, the LR clock and the sample.
// The slave side, which is the player, returns the serial data and status.
interface aud_i2s_player_if;
  logic        i_en;
  logic        i_mute;
  logic        i_daclrck;
  logic [15:0] i_dac_data;
  logic        o_aud_dacdat;
  logic        o_sample_done;
  logic        o_frame_err;
  logic [19:0] o_sample_cnt;

  modport master (
    output i_en,
    output i_mute,
    output i_daclrck,
    output i_dac_data,
    input  o_aud_dacdat,
    input  o_sample_done,
    input  o_frame_err,
    input  o_sample_cnt
  );

  modport slave (
    input  i_en,
    input  i_mute,
    input  i_daclrck,
    input  i_dac_data,
    output o_aud_dacdat,
    output o_sample_done,
    output o_frame_err,
    output o_sample_cnt
  );
endinterface

// File: rtl/aud_i2s_player.sv
// I2S DAC serialiser.
// On each qualifying LRCK edge it latches a 16-bit sample and shifts it out MSB first.
// The MSB leaves one BCLK after the LRCK change, which is the I2S delay.
// An LRCK edge that arrives mid-word aborts the word and sets a sticky frame error.
module aud_i2s_player #(
  parameter bit STEREO = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  aud_i2s_player_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  state_t      r_state;
  logic        r_lrck_d;
  logic [15:0] r_shift;
  logic [3:0]  r_bitcnt;
  logic        r_dacdat;
  logic        r_done;
  logic        r_err;
  logic [19:0] r_cnt;

  state_t      w_state_d;
  logic [15:0] w_shift_d;
  logic [3:0]  w_bitcnt_d;
  logic        w_dacdat_d;
  logic        w_done_d;
  logic        w_err_d;
  logic [19:0] w_cnt_d;

  logic        w_edge;
  logic        w_qual;
  logic [15:0] w_word;

  assign w_edge = bus.i_daclrck ^ r_lrck_d;
  // Mono mode only answers the falling edge, which starts the left half-frame.
  assign w_qual = w_edge & bus.i_en & (STEREO | ~bus.i_daclrck);
  assign w_word = bus.i_mute ? 16'h0000 : bus.i_dac_data;

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_bitcnt_d = r_bitcnt;
    w_dacdat_d = 1'b0;
    w_done_d   = 1'b0;
    w_err_d    = r_err;
    w_cnt_d    = r_cnt;
    if (w_edge) begin
      // Still in S_SEND means bit 0 has not been driven yet, so this word is cut short.
      if (r_state == S_SEND) begin
        w_err_d = 1'b1;
      end
      if (w_qual) begin
        w_state_d  = S_SEND;
        w_shift_d  = w_word;
        w_bitcnt_d = 4'd15;
        w_dacdat_d = w_word[15];
      end else if (!bus.i_en) begin
        w_state_d = S_IDLE;
      end else if (r_state != S_IDLE) begin
        w_state_d = S_HOLD;
      end
    end else begin
      case (r_state)
        S_SEND: begin
          w_shift_d  = {r_shift[14:0], 1'b0};
          w_dacdat_d = r_shift[14];
          w_bitcnt_d = r_bitcnt - 4'd1;
          if (r_bitcnt == 4'd1) begin
            // This cycle drives bit 0, so the word is now complete.
            w_done_d  = 1'b1;
            w_cnt_d   = r_cnt + 20'd1;
            w_state_d = S_HOLD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_lrck_d <= 1'b0;
      r_shift  <= 16'h0000;
      r_bitcnt <= 4'd0;
      r_dacdat <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 20'd0;
    end else begin
      r_state  <= w_state_d;
      r_lrck_d <= bus.i_daclrck;
      r_shift  <= w_shift_d;
      r_bitcnt <= w_bitcnt_d;
      r_dacdat <= w_dacdat_d;
      r_done   <= w_done_d;
      r_err    <= w_err_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign bus.o_aud_dacdat  = r_dacdat;
  assign bus.o_sample_done = r_done;
  assign bus.o_frame_err   = r_err;
  assign bus.o_sample_cnt  = r_cnt;

endmodule

// File: tb/tb_aud_i2s_player.sv
// Bench for aud_i2s_player: a stereo and a mono instance share the same stimulus.
// Both are compared every cycle against a word-schedule reference model.
module tb_aud_i2s_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mute = 1'b0;
  logic        lrck = 1'b0;
  logic [15:0] data = 16'h0000;
  int          lr_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;

  aud_i2s_player_if bus_s ();
  aud_i2s_player_if bus_m ();

  assign bus_s.i_en       = en;
  assign bus_s.i_mute     = mute;
  assign bus_s.i_daclrck  = lrck;
  assign bus_s.i_dac_data = data;
  assign bus_m.i_en       = en;
  assign bus_m.i_mute     = mute;
  assign bus_m.i_daclrck  = lrck;
  assign bus_m.i_dac_data = data;

  aud_i2s_player #(.STEREO(1'b1)) u_dut_s (.i_clk(clk), .i_rst(rst), .bus(bus_s));
  aud_i2s_player #(.STEREO(1'b0)) u_dut_m (.i_clk(clk), .i_rst(rst), .bus(bus_m));

  always #5 clk = ~clk;

  // Reference model. Index 0 is the stereo instance and index 1 is the mono one.
  // A word started at edge cycle N puts bit (15 - age) out at cycle N + age.
  logic        m_prev;
  bit          m_active [2];
  int          m_age    [2];
  logic [15:0] m_word   [2];
  logic [19:0] m_cnt    [2];
  bit          m_err    [2];
  bit          m_dat    [2];
  bit          m_done   [2];

  function automatic void model_clear();
    m_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_age[i]    = 0;
      m_word[i]   = 16'h0000;
      m_cnt[i]    = 20'd0;
      m_err[i]    = 1'b0;
      m_dat[i]    = 1'b0;
      m_done[i]   = 1'b0;
    end
  endfunction

  function automatic void model_step();
    bit lr_edge;
    bit qual;
    lr_edge = (lrck != m_prev);
    m_prev  = lrck;
    for (int i = 0; i < 2; i++) begin
      qual = lr_edge && en && ((i == 0) || !lrck);
      if (m_active[i]) m_age[i]++;
      if (lr_edge && m_active[i]) begin
        m_err[i]    = 1'b1;
        m_active[i] = 1'b0;
      end
      if (qual) begin
        m_active[i] = 1'b1;
        m_age[i]    = 0;
        m_word[i]   = mute ? 16'h0000 : data;
      end
      m_dat[i]  = m_active[i] ? m_word[i][15 - m_age[i]] : 1'b0;
      m_done[i] = 1'b0;
      if (m_active[i] && m_age[i] == 15) begin
        m_done[i]   = 1'b1;
        m_cnt[i]    = m_cnt[i] + 20'd1;
        m_active[i] = 1'b0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_out();
    check("dat_s",  {19'd0, bus_s.o_aud_dacdat},  {19'd0, m_dat[0]});
    check("done_s", {19'd0, bus_s.o_sample_done}, {19'd0, m_done[0]});
    check("err_s",  {19'd0, bus_s.o_frame_err},   {19'd0, m_err[0]});
    check("cnt_s",  bus_s.o_sample_cnt,           m_cnt[0]);
    check("dat_m",  {19'd0, bus_m.o_aud_dacdat},  {19'd0, m_dat[1]});
    check("done_m", {19'd0, bus_m.o_sample_done}, {19'd0, m_done[1]});
    check("err_m",  {19'd0, bus_m.o_frame_err},   {19'd0, m_err[1]});
    check("cnt_m",  bus_m.o_sample_cnt,           m_cnt[1]);
  endtask

  // Advance the model at the rising edge, then compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_clear();
    else model_step();
    @(negedge clk);
    check_out();
  endtask

  task automatic run(input int ncyc, input int half, input bit rnd);
    for (int c = 0; c < ncyc; c++) begin
      step();
      lr_cnt++;
      if (lr_cnt >= half) begin
        lrck   = ~lrck;
        lr_cnt = 0;
      end
      if (rnd) begin
        data = 16'($urandom);
        mute = (($urandom % 4) == 0);
      end
    end
  endtask

  // Assert reset between clock edges so the outputs must clear without a clock.
  task automatic reset_pulse(input bit lr_after);
    #2 rst = 1'b1;
    #1 model_clear();
    check_out();
    step();
    step();
    rst    = 1'b0;
    lrck   = lr_after;
    lr_cnt = 0;
  endtask

  initial begin
    #1 model_clear();
    check_out();
    step();
    step();
    rst = 1'b0;

    // Fixed word, 32-clock half-frames.
    en   = 1'b1;
    data = 16'hA5C3;
    run(200, 32, 1'b0);

    // Muted full-scale sample.
    reset_pulse(1'b0);
    mute = 1'b1;
    data = 16'h7FFF;
    run(140, 32, 1'b0);
    mute = 1'b0;

    // Half-frames too short for a word.
    reset_pulse(1'b0);
    data = 16'($urandom);
    run(100, 10, 1'b0);
    check("short_err_s", {19'd0, bus_s.o_frame_err}, 20'd1);
    check("short_err_m", {19'd0, bus_m.o_frame_err}, 20'd1);
    check("short_cnt_s", bus_s.o_sample_cnt, 20'd0);
    check("short_cnt_m", bus_m.o_sample_cnt, 20'd0);

    // Enable dropped while bit 8 is on the line. LRCK high at release counts as an edge.
    reset_pulse(1'b1);
    data = 16'h8001;
    run(8, 1000, 1'b0);
    en = 1'b0;
    run(100, 32, 1'b0);
    check("endrop_cnt_s", bus_s.o_sample_cnt, 20'd1);
    check("endrop_cnt_m", bus_m.o_sample_cnt, 20'd0);
    en = 1'b1;

    // Reset asserted while bit 5 is on the line, then normal operation resumes.
    reset_pulse(1'b1);
    data = 16'($urandom);
    run(11, 1000, 1'b0);
    reset_pulse(1'b0);
    run(80, 32, 1'b0);

    // Randomised frame lengths, enable, mute and data.
    for (int b = 0; b < 30; b++) begin
      int half;
      half = int'($urandom_range(6, 40));
      en   = (($urandom % 6) != 0);
      run(int'($urandom_range(2, 4)) * half, half, 1'b1);
      if (($urandom % 10) == 0) reset_pulse(1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
